// File: rtl/fetch_queue.sv
// fetch_queue: prefetch buffer between instruction memory and IF/ID.
// Buffers (instruction, PC) pairs so fetch can run ahead while decode stalls.
// A taken branch (flush) drops every wrong-path entry in a single cycle.
// The head entry is shown ahead on out_inst/out_pc. When the queue is empty
// these outputs carry NOP_WORD and 0.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, an empty
// queue passes the input straight to the output if decode is ready.
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              IW       = 32,
  parameter int              PW       = 32,
  parameter logic [IW-1:0]   NOP_WORD = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IW-1:0]          in_inst,
  input  logic [PW-1:0]          in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IW-1:0]          out_inst,
  output logic [PW-1:0]          out_pc,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [IW-1:0] inst_mem_r [DEPTH];
  logic [PW-1:0] pc_mem_r   [DEPTH];

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          full_r;
  logic          empty_r;

  logic          bypass_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] count_nxt_s;

  // Handshake qualification: flush overrides everything, full blocks a push
  // even when a pop happens in the same cycle.
  always_comb begin
    bypass_s = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s = empty_r & in_valid & out_ready & ~flush;
`endif
    push_s = in_valid & ~full_r & ~flush & ~bypass_s;
    pop_s  = ~empty_r & out_ready & ~flush;
  end

  // Occupancy after this edge, ignoring flush (flush is applied in the register).
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer and occupancy registers. full/empty are registered copies of count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else if (flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == CNT_ZERO);
    end
  end

  // Entry storage. Contents are don't-care until written, so there is no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_r[wr_ptr_r] <= in_inst;
      pc_mem_r[wr_ptr_r]   <= in_pc;
    end
  end

  // Show-ahead output: bypass input, head entry, or NOP when nothing is valid.
  always_comb begin
    out_valid = 1'b0;
    out_inst  = NOP_WORD;
    out_pc    = {PW{1'b0}};
    if (bypass_s) begin
      out_valid = 1'b1;
      out_inst  = in_inst;
      out_pc    = in_pc;
    end else if (!empty_r) begin
      out_valid = 1'b1;
      out_inst  = inst_mem_r[rd_ptr_r];
      out_pc    = pc_mem_r[rd_ptr_r];
    end else begin
      out_valid = 1'b0;
      out_inst  = NOP_WORD;
      out_pc    = {PW{1'b0}};
    end
  end

  assign in_ready = ~full_r;
  assign count    = count_r;
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue.
// The driver keeps a plain queue of expected (inst, pc) pairs. Entries are
// pushed when the queue rules accept a push, and the queue is cleared on
// flush. A negedge monitor compares the DUT outputs against the queue head
// and pops the head on every handshake.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } item_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_inst = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  item_t exp_q[$];
  item_t pend_item;
  logic  pend_push  = 1'b0;
  logic  pend_flush = 1'b0;
  int    total = 0;
  int    bad   = 0;
  logic [31:0] pc_ctr;

  fetch_queue #(.DEPTH(DEPTH), .IW(32), .PW(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .flush(flush), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Apply last cycle's accepted ops at the edge, then drive new inputs and
  // decide from the queue rules whether they will be accepted.
  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    int   sz;
    logic byp;
    @(posedge clk);
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_item);
    #1;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    sz  = exp_q.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && v && rdy && !fl;
`endif
    pend_flush = reset && fl;
    pend_push  = reset && v && (sz < DEPTH) && !fl && !byp;
    pend_item  = '{inst: inst, pc: pc};
  endtask

  // Monitor: status and head outputs against the expected queue.
  always @(negedge clk) begin
    int sz;
    sz = exp_q.size();
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
    if (sz == 0 && in_valid && out_ready && !flush && reset) begin
      chk("byp_valid", 64'(out_valid), 64'd1);
      chk("byp_inst", 64'(out_inst), 64'(in_inst));
      chk("byp_pc", 64'(out_pc), 64'(in_pc));
    end else
`endif
    if (sz > 0) begin
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("out_inst", 64'(out_inst), 64'(exp_q[0].inst));
      chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
      if (out_ready && !flush && reset) void'(exp_q.pop_front());
    end else begin
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_inst", 64'(out_inst), 64'(NOP));
      chk("idle_pc", 64'(out_pc), 64'd0);
    end
  end

  initial begin
    // Power-on reset.
    #1 reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'(NOP));
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    // Empty queue, decode ready.
    drive(1'b1, 32'h1234_5678, 32'h0000_0040, 1'b1, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_same_cycle_inst", 64'(out_inst), 64'h1234_5678);
    chk("byp_same_cycle_count", 64'(count), 64'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("byp_after_count", 64'(count), 64'd0);
`else
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("lat_inst", 64'(out_inst), 64'h1234_5678);
    chk("lat_count1", 64'(count), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("lat_count0", 64'(count), 64'd0);
`endif

    // Fill to full while decode stalls; the fifth push must be dropped.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hA000_0001 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'hA000_0005, 32'h0000_0010, 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk("fill_count", 64'(count), 64'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("fill5_count", 64'(count), 64'd4);
    chk("fill5_head_pc", 64'(out_pc), 64'h0);

    // Drain to two, then push and pop together for six cycles.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hB000_0000 + 32'(i), 32'h20 + 32'(4 * i), 1'b1, 1'b0);
      chk("pp_count", 64'(count), 64'd2);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("pp_count_end", 64'(count), 64'd2);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with three entries and a concurrent push.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hC000_0000 + 32'(i), 32'h80 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_0000, 32'h0000_00F0, 1'b0, 1'b1);
    chk("pre_flush_count", 64'(count), 64'd3);
    drive(1'b1, 32'h0000_0055, 32'h0000_0100, 1'b0, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("post_flush_inst", 64'(out_inst), 64'h55);
    chk("post_flush_count", 64'(count), 64'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Interleaved push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hD000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges with three entries held.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hE000_0000 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_empty", 64'(empty), 64'd1);
    chk("async_rst_inst", 64'(out_inst), 64'(NOP));
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;

    // Randomized traffic with occasional flushes.
    pc_ctr = 32'h0000_1000;
    for (int i = 0; i < 600; i++) begin
      logic v, r, f;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < ((i < 300) ? 50 : 75));
      f = ($urandom_range(0, 99) < 4);
      drive(v, $urandom, pc_ctr, r, f);
      if (v) pc_ctr = pc_ctr + 32'd4;
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("final_empty", 64'(empty), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Prefetch buffer between instruction memory and the IF/ID pipeline register. It queues (instruction, PC) pairs from the fetch side so that fetch can keep running while decode is stalled by the hazard unit. On a taken branch it discards all wrong-path entries in one cycle. Its output drives the instruction and PC inputs of IF/ID directly.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
IW, 32, instruction width in bits
PW, 32, PC (IAOQ front) width in bits
NOP_WORD, 32'h0000_0000, value driven on out_inst when the queue is empty

Ports:
clk  input  1  pipeline clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low; clears all state
in_valid  input  1  fetch side presents a valid instruction/PC pair
in_ready  output  1  queue can accept a push this cycle
in_inst  input  IW  instruction word from instruction memory
in_pc  input  PW  IAOQ front value of in_inst
out_valid  output  1  head entry valid
out_ready  input  1  decode consumes the head this cycle (hazard-unit LE)
out_inst  output  IW  head instruction, or NOP_WORD when empty
out_pc  output  PW  head PC, or 0 when empty
flush  input  1  taken branch (CH jump output); discard all entries
count  output  $clog2(DEPTH)+1  number of occupied entries
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0. Outputs: empty=1, full=0, out_valid=0, in_ready=1, out_inst=NOP_WORD, out_pc=0. Storage contents are don't-care.
- Release of reset is synchronous to clk. The first push can occur on the first rising edge after reset goes high.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- in_ready = ~full, combinational from count. A push into a full queue is not allowed, even if a pop happens in the same cycle.
- out_valid = ~empty.
- out_inst and out_pc come from the head entry (show-ahead). When empty they are forced to NOP_WORD and 0.
- Latency: an entry pushed at edge N appears at the outputs after edge N, i.e. one cycle of latency with no bypass.
- Push: store at wr_ptr; wr_ptr advances by 1 modulo DEPTH.
- Pop: rd_ptr advances by 1 modulo DEPTH.
- count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
  - neither: unchanged
- Flush has priority over everything:
  - On the edge where flush=1: wr_ptr=rd_ptr=0, count=0. Any push or pop in that cycle is discarded.
  - The next cycle shows empty=1.
  - A push in the cycle immediately after flush is accepted normally.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full and empty come only from count, never from pointer comparison.
- Stall: while out_ready=0, the head and its outputs are held stable. Pushes continue until full.
- Underflow/overflow are impossible by construction: pop is gated by ~empty and push by ~full. count never leaves 0..DEPTH.
- No X on any output after reset.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when empty=1, in_valid=1, out_ready=1 and flush=0, the input passes combinationally to the output in the same cycle. out_valid=1, out_inst=in_inst, out_pc=in_pc, and nothing is stored; count stays 0. In that case in_valid&out_ready counts as both push and pop.
- Defined, empty but out_ready=0: the entry is stored normally.
- Not defined: the queue always has 1-cycle latency, and out_valid depends only on count.

Test Plan:
- Reset mid-operation: fill 3 entries, assert reset=0 asynchronously between edges -> count=0, empty=1, out_inst=32'h0 immediately, without waiting for a clock edge.
- Fill to full: out_ready=0; push PCs 0x00, 0x04, 0x08, 0x0C with instructions 0xA0000001..0xA0000004 -> full=1 and in_ready=0 after edge 4; a fifth push is ignored, count=4; out_pc=0x00 is held throughout.
- Simultaneous push/pop: count=2 with out_ready=1 and in_valid=1 for 6 cycles -> count stays 2; outputs are popped in push order with no gaps.
- Wrap-around: 10 pushes and 10 pops with DEPTH=4, interleaved -> output PC sequence exactly matches the input sequence.
- Flush: count=3, assert flush with in_valid=1 and in_inst=0xDEAD0000 -> next cycle count=0, empty=1, and 0xDEAD0000 is never output. A push the following cycle appears one cycle later.
- Bypass: empty, in_valid=1, out_ready=1, in_inst=0x12345678 -> with FETCH_QUEUE_BYPASS_EN, out_inst=0x12345678 in the same cycle and count stays 0; without it, out_inst=0x12345678 one cycle later with count=1 then 0.
